sccb_write_master: RTL
======================

Name: sccb_write_master

Overview:
- Byte-level SCCB/I2C write engine for the OV5640 configuration path.
- Sits directly downstream of the register-configuration sequencer.
- Takes one 32-bit word {device addr, reg addr hi, reg addr lo, data}, serialises it as a 4-byte I2C write on the camera control bus, and reports completion and acknowledge status.
- Runs from the 25 MHz system clock, with an internal quarter-bit tick divider; it does not use a derived slow clock.

Parameters:
- CLK_FREQ_HZ, 25_000_000, frequency of clk_25M.
- SCL_FREQ_HZ, 100_000, target SCL rate.
- QDIV, CLK_FREQ_HZ/(4*SCL_FREQ_HZ), clk_25M cycles per quarter-bit tick (minimum 1). Default value is 62.

Ports:
- clk_25M  in  1  system clock.
- camera_rst  in  1  synchronous, active-high reset.
- start  in  1  level request; held high by the sequencer until tr_end is seen.
- i2c_data  in  32  [31:24] device addr (0x78 for write), [23:8] register addr, [7:0] data.
- tr_end  out  1  transaction finished; held high while start stays high.
- ack_err  out  1  a NACK occurred in the last transaction; valid while tr_end=1.
- busy  out  1  high from transaction accept until tr_end rises.
- i2c_sclk  out  1  SCL, push-pull.
- i2c_sdat  inout  1  SDA, open-drain: the block drives 0 or Z, never 1.

Behaviour:
- One clock (clk_25M). Reset is synchronous and active-high (camera_rst); all state is cleared on a rising clk_25M edge while camera_rst=1.
- Reset values: tr_end=0, ack_err=0, busy=0, i2c_sclk=1, i2c_sdat=Z, state=IDLE, tick counter=0.
- Reset mid-transaction: the bus is released on the next edge (SCL=1, SDA=Z). No STOP is generated.
- Tick generator:
  - Counts 0..QDIV-1 and emits a 1-cycle tick on QDIV-1.
  - Free-runs only while state≠IDLE; it is held at 0 in IDLE.
- States: IDLE, START, SHIFT, ACK, STOP, DONE. Each bit spends 4 ticks, phases q0..q3.
- IDLE:
  - SCL=1, SDA=Z.
  - If start=1 and tr_end=0: latch i2c_data into a shift register, byte_cnt=0, clear ack_err, set busy=1, go to START.
- START (4 ticks):
  - q0, q1: SDA=Z, SCL=1.
  - q2: SDA=0, SCL=1 (start condition).
  - q3: SCL=0.
  - Then go to SHIFT with bit_cnt=7.
- SHIFT, per bit MSB first:
  - q0: SCL=0, drive SDA (0 → drive 0, 1 → Z).
  - q1: SCL=1.
  - q2: SCL=1.
  - q3: SCL=0.
  - After bit 0, go to ACK.
- ACK:
  - SDA=Z, same SCL phases as SHIFT.
  - SDA is sampled on the tick ending q1 (mid SCL-high).
  - Sampled 1 = NACK: set ack_err and go to STOP (abort the remaining bytes).
  - Sampled 0: increment byte_cnt; go to SHIFT if byte_cnt<4, else go to STOP.
- STOP (4 ticks):
  - q0: SCL=0, SDA=0.
  - q1: SCL=1, SDA=0.
  - q2: SCL=1, SDA=Z (stop condition).
  - q3: idle.
  - Then go to DONE.
- DONE:
  - tr_end=1 and busy=0, registered, rising 1 cycle after the final STOP tick.
  - Remains in DONE while start=1. When start=0, go to IDLE; tr_end falls on that same edge.
- Full transaction length is 4 + 4×9×4 + 4 = 152 ticks = 152×QDIV clk_25M cycles.
- start deasserting mid-transaction is ignored: the transaction completes, DONE sees start=0, and the block returns to IDLE.
- i2c_data changes after accept are ignored.
- start already high at reset release starts a transaction on the first IDLE cycle.

Decomposition:
- Shared package sccb_pkg:
  - state enum (IDLE, START, SHIFT, ACK, STOP, DONE).
  - SCCB_BYTES=4.
  - BITS_PER_BYTE=8.
  - OV5640_WR_ADDR=8'h78.
  - quarter-phase constants Q0..Q3.
- One sub-module: sccb_tick_gen (QDIV counter with enable, emits tick).

Test Plan:
- CLK_FREQ_HZ=400_000 and SCL_FREQ_HZ=100_000 (QDIV=1); slave model ACKs all bytes; i2c_data=32'h78_3103_11 → SDA bytes 78,31,03,11 decoded MSB-first; start/stop conditions present; tr_end rises at accept+153 cycles; ack_err=0.
- Slave NACKs the 2nd byte → only 2 bytes on the bus, then STOP; tr_end=1, ack_err=1, total 4+72+4=80 ticks.
- Hold start=1 for 50 cycles after tr_end → tr_end stays 1 and no new transaction starts; drop start → tr_end=0 next edge; raise start again → new transaction accepted.
- Assert camera_rst at tick 40 mid-SHIFT → next edge: SCL=1, SDA=Z, busy=0, tr_end=0; after release with start=1, a fresh full transaction runs.
- Default parameters (QDIV=62) → SCL period measured as 248 clk_25M cycles (~100.8 kHz); SDA only changes while SCL=0, except at start/stop.
- Change i2c_data mid-transaction → bus carries the originally latched word.

Source files
------------

// File: rtl/sccb_pkg.sv
// ---------------------------------------------------------------------------
// sccb_pkg
// Shared types and constants for the SCCB (I2C-compatible) write engine that
// drives the OV5640 configuration bus.
//   - sccb_state_e : engine state encoding
//   - SCCB_BYTES, BITS_PER_BYTE : frame geometry (4 bytes of 8 bits)
//   - OV5640_WR_ADDR : camera 8-bit write address
//   - Q0..Q3 : quarter-bit phase indices
//   - sccb_word() : packs {device addr, register addr, data} into one word
// ---------------------------------------------------------------------------
package sccb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        SHIFT = 3'd2,
        ACK   = 3'd3,
        STOP  = 3'd4,
        DONE  = 3'd5
    } sccb_state_e;

    localparam int SCCB_BYTES    = 4;
    localparam int BITS_PER_BYTE = 8;

    localparam logic [7:0] OV5640_WR_ADDR = 8'h78;

    typedef logic [1:0] qphase_t;

    localparam qphase_t Q0 = 2'd0;
    localparam qphase_t Q1 = 2'd1;
    localparam qphase_t Q2 = 2'd2;
    localparam qphase_t Q3 = 2'd3;

    // Build a complete write word for the OV5640 from a 16-bit register
    // address and an 8-bit value.
    function automatic logic [31:0] sccb_word(input logic [15:0] reg_addr,
                                              input logic [7:0]  data);
        return {OV5640_WR_ADDR, reg_addr, data};
    endfunction

endpackage

// File: rtl/sccb_write_master_if.sv
// ---------------------------------------------------------------------------
// sccb_write_master_if
// Request/completion handshake between the register-configuration sequencer
// (master modport) and the SCCB write engine (slave modport).
//   start    : level request, held by the sequencer until tr_end is seen
//   i2c_data : {device addr, reg addr hi, reg addr lo, data}
//   tr_end   : transaction finished, held while start stays high
//   ack_err  : a NACK occurred in the last transaction (valid with tr_end)
//   busy     : engine has accepted a word and not yet finished it
// ---------------------------------------------------------------------------
interface sccb_write_master_if;

    logic        start;
    logic [31:0] i2c_data;
    logic        tr_end;
    logic        ack_err;
    logic        busy;

    modport master (
        output start,
        output i2c_data,
        input  tr_end,
        input  ack_err,
        input  busy
    );

    modport slave (
        input  start,
        input  i2c_data,
        output tr_end,
        output ack_err,
        output busy
    );

endinterface

// File: rtl/sccb_tick_gen.sv
// ---------------------------------------------------------------------------
// sccb_tick_gen
// Quarter-bit tick divider. Counts 0..QDIV-1 while en is high and emits a
// single-cycle tick on the last count; held at 0 whenever en is low, so the
// first tick after enabling always arrives QDIV cycles later.
//   clk  : system clock
//   srst : synchronous active-high reset
//   en   : run enable
//   tick : one-cycle pulse every QDIV enabled cycles
// ---------------------------------------------------------------------------
module sccb_tick_gen #(
    parameter int QDIV = 62
) (
    input  logic clk,
    input  logic srst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(QDIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (!en || (count_q == LAST)) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = en && (count_q == LAST);

endmodule

// File: rtl/sccb_write_master.sv
// ---------------------------------------------------------------------------
// sccb_write_master
// Serialises one 32-bit word as a 4-byte SCCB/I2C write (START, 4 x (8 data
// bits + ACK slot), STOP) and reports completion and acknowledge status.
// Every bit is four quarter-bit ticks long; SCL/SDA are registered so both
// pins change on the same clock edge.
//   clk_25M    : system clock
//   camera_rst : synchronous active-high reset
//   ctrl       : handshake with the configuration sequencer (slave side)
//   i2c_sclk   : SCL, push-pull
//   i2c_sdat   : SDA, open-drain (drives 0 or releases)
// ---------------------------------------------------------------------------
module sccb_write_master
    import sccb_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int SCL_FREQ_HZ = 100_000,
    parameter int QDIV = ((CLK_FREQ_HZ / (4 * SCL_FREQ_HZ)) < 1) ? 1
                         : (CLK_FREQ_HZ / (4 * SCL_FREQ_HZ))
) (
    input  logic                  clk_25M,
    input  logic                  camera_rst,
    sccb_write_master_if.slave    ctrl,
    output logic                  i2c_sclk,
    inout  wire                   i2c_sdat
);

    sccb_state_e state_q, state_d;
    qphase_t     phase_q, phase_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shreg_q, shreg_d;
    logic        ack_bit_q, ack_bit_d;
    logic        ack_err_q, ack_err_d;
    logic        busy_q, busy_d;
    logic        tr_end_q, tr_end_d;
    logic        scl_q, scl_d;
    logic        sda_low_q, sda_low_d;
    logic        sda_in_q;
    logic        tick;

    sccb_tick_gen #(
        .QDIV (QDIV)
    ) u_tick (
        .clk  (clk_25M),
        .srst (camera_rst),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    // State register; pin outputs and the SDA input sample live here too.
    always_ff @(posedge clk_25M) begin
        if (camera_rst) begin
            state_q    <= IDLE;
            phase_q    <= Q0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shreg_q    <= '0;
            ack_bit_q  <= 1'b1;
            ack_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            tr_end_q   <= 1'b0;
            scl_q      <= 1'b1;
            sda_low_q  <= 1'b0;
            sda_in_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            ack_bit_q  <= ack_bit_d;
            ack_err_q  <= ack_err_d;
            busy_q     <= busy_d;
            tr_end_q   <= tr_end_d;
            scl_q      <= scl_d;
            sda_low_q  <= sda_low_d;
            // Single register stage on the slave-driven line; the ACK slot
            // is sampled at the end of q1, long after the slave has settled.
            sda_in_q   <= i2c_sdat;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        ack_bit_d  = ack_bit_q;
        ack_err_d  = ack_err_q;
        busy_d     = busy_q;
        tr_end_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                phase_d = Q0;
                if (ctrl.start && !tr_end_q) begin
                    shreg_d    = ctrl.i2c_data;
                    byte_cnt_d = '0;
                    bit_cnt_d  = 3'(BITS_PER_BYTE - 1);
                    ack_err_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = START;
                end
            end

            START: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == Q3) begin
                        bit_cnt_d = 3'(BITS_PER_BYTE - 1);
                        state_d   = SHIFT;
                    end
                end
            end

            SHIFT: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == Q3) begin
                        // MSB of the shift register is always the bit on the wire.
                        shreg_d = {shreg_q[30:0], 1'b0};
                        if (bit_cnt_q == 3'd0) begin
                            state_d = ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end
            end

            ACK: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == Q1) begin
                        ack_bit_d = sda_in_q;
                    end
                    if (phase_q == Q3) begin
                        if (ack_bit_q) begin
                            // NACK: abandon remaining bytes and close the frame.
                            ack_err_d = 1'b1;
                            state_d   = STOP;
                        end else if (byte_cnt_q == 3'(SCCB_BYTES - 1)) begin
                            byte_cnt_d = byte_cnt_q + 3'd1;
                            state_d    = STOP;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 3'd1;
                            bit_cnt_d  = 3'(BITS_PER_BYTE - 1);
                            state_d    = SHIFT;
                        end
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == Q3) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                phase_d  = Q0;
                busy_d   = 1'b0;
                // tr_end follows start so it drops on the same edge as the
                // return to IDLE, and IDLE never sees a stale tr_end.
                tr_end_d = ctrl.start;
                if (!ctrl.start) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                phase_d = Q0;
            end
        endcase
    end

    // Output decode: bus levels for the current state/phase
    always_comb begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;

        unique case (state_q)
            START: begin
                scl_d     = (phase_q != Q3);
                sda_low_d = (phase_q == Q2) || (phase_q == Q3);
            end
            SHIFT: begin
                scl_d     = (phase_q == Q1) || (phase_q == Q2);
                sda_low_d = !shreg_q[31];
            end
            ACK: begin
                scl_d     = (phase_q == Q1) || (phase_q == Q2);
                sda_low_d = 1'b0;
            end
            STOP: begin
                scl_d     = (phase_q != Q0);
                sda_low_d = (phase_q == Q0) || (phase_q == Q1);
            end
            default: begin
                scl_d     = 1'b1;
                sda_low_d = 1'b0;
            end
        endcase
    end

    assign i2c_sclk     = scl_q;
    assign i2c_sdat     = sda_low_q ? 1'b0 : 1'bz;
    assign ctrl.tr_end  = tr_end_q;
    assign ctrl.ack_err = ack_err_q;
    assign ctrl.busy    = busy_q;

endmodule
